tagged_regfile: RTL and testbench

Parametrised architectural register file with per-register rename tags for the out-of-order core. It sits between decode/issue and the reservation stations. For every issued instruction it returns, per source operand, either a ready value or the tag of the in-flight producer. On commit it writes results back and clears tags that are still current. Compared with the first-generation file it adds a configurable source-port count, same-cycle commit bypass, x0 hardwiring, a pipeline flush and a busy-register counter.

---
 rtl/rf_pkg.sv | 15 +
 rtl/rf_src_read.sv | 36 +++
 rtl/tagged_regfile.sv | 110 +++++++++++
 tb/tb_tagged_regfile.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the tagged register file.
// Tag value 0 is reserved to mean "no in-flight producer".
package rf_pkg;

   localparam int XLEN_DEF  = 32;
   localparam int NREG_DEF  = 32;
   localparam int TAG_W_DEF = 3;
   localparam int NSRC_DEF  = 2;

   localparam int TAG_NONE  = 0;

   typedef logic [TAG_W_DEF-1:0]         tag_t;
   typedef logic [$clog2(NREG_DEF)-1:0]  reg_idx_t;

endpackage

// File: rtl/rf_src_read.sv
// One source-operand read slot: x0 forcing, same-cycle commit bypass, tag/value select.
// Purely combinational; the caller registers the result.
module rf_src_read
   import rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int RW    = $clog2(NREG_DEF),
   parameter int TAG_W = TAG_W_DEF
) (
   input  logic [RW-1:0]    rs,
   input  logic [XLEN-1:0]  reg_val,
   input  logic [TAG_W-1:0] reg_tag,
   input  logic             commit_valid,
   input  logic [RW-1:0]    commit_rd,
   input  logic [TAG_W-1:0] commit_tag,
   input  logic [XLEN-1:0]  commit_data,
   output logic [XLEN-1:0]  val,
   output logic [TAG_W-1:0] tag
);

   always_comb begin
      val = '0;
      tag = TAG_W'(TAG_NONE);
      if (rs == '0) begin
         val = '0;
      end else if (commit_valid && commit_rd == rs && commit_tag == reg_tag) begin
         // Producer retires this very cycle: forward its result instead of the stale array value.
         val = commit_data;
      end else if (reg_tag == TAG_W'(TAG_NONE)) begin
         val = reg_val;
      end else begin
         tag = reg_tag;
      end
   end

endmodule

// File: rtl/tagged_regfile.sv
// Register file with rename tags: 1-cycle registered source read per issue, commit write-back
// with current-tag clear, flush of all tags, busy-register count; no back-pressure.
module tagged_regfile
   import rf_pkg::*;
#(
   parameter int XLEN  = XLEN_DEF,
   parameter int NREG  = NREG_DEF,
   parameter int TAG_W = TAG_W_DEF,
   parameter int NSRC  = NSRC_DEF
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         issue_valid,
   input  logic [NSRC*$clog2(NREG)-1:0] issue_rs,
   input  logic [$clog2(NREG)-1:0]      issue_rd,
   input  logic [TAG_W-1:0]             issue_tag,
   input  logic                         commit_valid,
   input  logic [$clog2(NREG)-1:0]      commit_rd,
   input  logic [TAG_W-1:0]             commit_tag,
   input  logic [XLEN-1:0]              commit_data,
   input  logic                         flush,
   output logic                         src_valid,
   output logic [NSRC*XLEN-1:0]         src_val,
   output logic [NSRC*TAG_W-1:0]        src_tag,
   output logic [$clog2(NREG+1)-1:0]    busy_cnt
);

   localparam int RW = $clog2(NREG);
   localparam int CW = $clog2(NREG+1);

   logic [XLEN-1:0]      regs_q [NREG];
   logic [TAG_W-1:0]     tags_q [NREG];
   logic [CW-1:0]        busy_q, busy_d;
   logic                 src_valid_q;
   logic [NSRC*XLEN-1:0] src_val_q, src_val_d;
   logic [NSRC*TAG_W-1:0] src_tag_q, src_tag_d;

   logic issue_go, rename, clr, inc, dec;

   assign issue_go = issue_valid && !flush;
   assign rename   = issue_go && issue_rd != '0 && issue_tag != TAG_W'(TAG_NONE);
   assign clr      = commit_valid && commit_rd != '0 && commit_tag != TAG_W'(TAG_NONE)
                     && tags_q[commit_rd] == commit_tag;
   assign inc      = rename && tags_q[issue_rd] == TAG_W'(TAG_NONE);
   // A rename of the register being cleared keeps it busy, so the clear does not count.
   assign dec      = clr && !(rename && issue_rd == commit_rd);

   always_comb begin
      busy_d = busy_q;
      if (flush)
         busy_d = '0;
      else if (inc && !dec)
         busy_d = busy_q + CW'(1);
      else if (dec && !inc)
         busy_d = busy_q - CW'(1);
   end

   for (genvar k = 0; k < NSRC; k++) begin : g_src
      logic [RW-1:0] rs;
      assign rs = issue_rs[k*RW +: RW];
      rf_src_read #(.XLEN(XLEN), .RW(RW), .TAG_W(TAG_W)) u_rd (
         .rs          (rs),
         .reg_val     (regs_q[rs]),
         .reg_tag     (tags_q[rs]),
         .commit_valid(commit_valid),
         .commit_rd   (commit_rd),
         .commit_tag  (commit_tag),
         .commit_data (commit_data),
         .val         (src_val_d[k*XLEN +: XLEN]),
         .tag         (src_tag_d[k*TAG_W +: TAG_W])
      );
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NREG; i++) begin
            regs_q[i] <= '0;
            tags_q[i] <= '0;
         end
         busy_q      <= '0;
         src_valid_q <= 1'b0;
         src_val_q   <= '0;
         src_tag_q   <= '0;
      end else begin
         if (commit_valid && commit_rd != '0)
            regs_q[commit_rd] <= commit_data;
         if (flush) begin
            for (int i = 0; i < NREG; i++)
               tags_q[i] <= '0;
         end else begin
            if (clr)
               tags_q[commit_rd] <= '0;
            if (rename)
               tags_q[issue_rd] <= issue_tag;
         end
         busy_q      <= busy_d;
         src_valid_q <= issue_go;
         if (issue_go) begin
            src_val_q <= src_val_d;
            src_tag_q <= src_tag_d;
         end
      end
   end

   assign src_valid = src_valid_q;
   assign src_val   = src_val_q;
   assign src_tag   = src_tag_q;
   assign busy_cnt  = busy_q;

endmodule

// File: tb/tb_tagged_regfile.sv
// Directed bench for tagged_regfile: expected source results are queued at issue and
// checked by an independent monitor whenever src_valid is seen.
module tb_tagged_regfile;

   logic        clk = 1'b0;
   logic        rst;
   logic        issue_valid;
   logic [9:0]  issue_rs;
   logic [4:0]  issue_rd;
   logic [2:0]  issue_tag;
   logic        commit_valid;
   logic [4:0]  commit_rd;
   logic [2:0]  commit_tag;
   logic [31:0] commit_data;
   logic        flush;
   logic        src_valid;
   logic [63:0] src_val;
   logic [5:0]  src_tag;
   logic [5:0]  busy_cnt;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [31:0] v0;
      logic [2:0]  t0;
      logic [31:0] v1;
      logic [2:0]  t1;
   } exp_t;

   exp_t exp_q[$];

   always #5 clk = ~clk;

   tagged_regfile dut (
      .clk         (clk),
      .rst         (rst),
      .issue_valid (issue_valid),
      .issue_rs    (issue_rs),
      .issue_rd    (issue_rd),
      .issue_tag   (issue_tag),
      .commit_valid(commit_valid),
      .commit_rd   (commit_rd),
      .commit_tag  (commit_tag),
      .commit_data (commit_data),
      .flush       (flush),
      .src_valid   (src_valid),
      .src_val     (src_val),
      .src_tag     (src_tag),
      .busy_cnt    (busy_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
      end
   endtask

   // Monitor: every src_valid pulse must match the oldest queued expectation.
   always @(negedge clk) begin
      if (rst === 1'b1 && src_valid === 1'b1) begin
         exp_t e;
         if (exp_q.size() == 0) begin
            check("unexpected_src_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            check("src_val0", src_val[31:0],  e.v0);
            check("src_tag0", 32'(src_tag[2:0]), 32'(e.t0));
            check("src_val1", src_val[63:32], e.v1);
            check("src_tag1", 32'(src_tag[5:3]), 32'(e.t1));
         end
      end
   end

   task automatic clear_inputs();
      issue_valid = 0; issue_rs = '0; issue_rd = '0; issue_tag = '0;
      commit_valid = 0; commit_rd = '0; commit_tag = '0; commit_data = '0;
      flush = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
      clear_inputs();
   endtask

   // Drive an issue; push the expected result unless a flush drops it.
   task automatic do_issue(input logic [4:0] rs0, input logic [4:0] rs1, input logic [4:0] rd,
                           input logic [2:0] tag, input logic [31:0] v0, input logic [2:0] t0,
                           input logic [31:0] v1, input logic [2:0] t1, input bit expect_out);
      exp_t e;
      issue_valid = 1; issue_rs = {rs1, rs0}; issue_rd = rd; issue_tag = tag;
      if (expect_out) begin
         e.v0 = v0; e.t0 = t0; e.v1 = v1; e.t1 = t1;
         exp_q.push_back(e);
      end
   endtask

   task automatic do_commit(input logic [4:0] rd, input logic [2:0] tag, input logic [31:0] data);
      commit_valid = 1; commit_rd = rd; commit_tag = tag; commit_data = data;
   endtask

   task automatic check_busy(input string name, input int req);
      check(name, 32'(busy_cnt), 32'(req));
   endtask

   initial begin
      clear_inputs();
      rst = 0;
      do_commit(5'd1, 3'd0, 32'hFFFF_FFFF);   // reset must dominate commit
      repeat (2) @(posedge clk);
      #1;
      check("rst_src_valid", 32'(src_valid), 32'd0);
      check("rst_src_val", src_val[31:0] | src_val[63:32], 32'd0);
      check("rst_src_tag", 32'(src_tag), 32'd0);
      check_busy("rst_busy", 0);
      clear_inputs();
      rst = 1;
      tick();

      // Plain read of ready registers, rename x3 -> tag 5.
      do_issue(5'd1, 5'd2, 5'd3, 3'd5, 32'h0, 3'd0, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_after_rename", 1);

      // x3 is in flight; x0 is always ready zero.
      do_issue(5'd3, 5'd0, 5'd0, 3'd0, 32'h0, 3'd5, 32'h0, 3'd0, 1);
      tick();

      // Same-cycle commit of x3 bypasses to the reader.
      do_commit(5'd3, 3'd5, 32'hDEAD_BEEF);
      do_issue(5'd3, 5'd1, 5'd0, 3'd0, 32'hDEAD_BEEF, 3'd0, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_after_commit", 0);

      // Later reads come from the array.
      do_issue(5'd3, 5'd3, 5'd0, 3'd0, 32'hDEAD_BEEF, 3'd0, 32'hDEAD_BEEF, 3'd0, 1);
      tick();

      // Rename x4 twice; the read in the second rename sees the older tag.
      do_issue(5'd0, 5'd0, 5'd4, 3'd2, 32'h0, 3'd0, 32'h0, 3'd0, 1);
      tick();
      do_issue(5'd4, 5'd0, 5'd4, 3'd6, 32'h0, 3'd2, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_double_rename", 1);

      // Stale commit to x4: data written, younger tag 6 survives, no bypass.
      do_commit(5'd4, 3'd2, 32'h0000_1234);
      do_issue(5'd4, 5'd0, 5'd0, 3'd0, 32'h0, 3'd6, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_stale_commit", 1);
      do_issue(5'd4, 5'd0, 5'd0, 3'd0, 32'h0, 3'd6, 32'h0, 3'd0, 1);
      tick();

      // x7 rename tag 1, then same-cycle current commit + rename to tag 4.
      do_issue(5'd0, 5'd0, 5'd7, 3'd1, 32'h0, 3'd0, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_x7_rename", 2);
      do_commit(5'd7, 3'd1, 32'h0000_0077);
      do_issue(5'd7, 5'd4, 5'd7, 3'd4, 32'h0000_0077, 3'd0, 32'h0, 3'd6, 1);
      tick();
      check_busy("busy_commit_rename_same", 2);
      do_issue(5'd7, 5'd0, 5'd0, 3'd0, 32'h0, 3'd4, 32'h0, 3'd0, 1);
      tick();

      // x0 rename and commit are ignored.
      do_commit(5'd0, 3'd3, 32'h0000_0055);
      do_issue(5'd0, 5'd0, 5'd0, 3'd3, 32'h0, 3'd0, 32'h0, 3'd0, 1);
      tick();
      do_issue(5'd0, 5'd0, 5'd0, 3'd0, 32'h0, 3'd0, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_x0_ignored", 2);

      // Third busy register, then flush with an issue and a stale commit of x9.
      do_issue(5'd0, 5'd0, 5'd9, 3'd5, 32'h0, 3'd0, 32'h0, 3'd0, 1);
      tick();
      check_busy("busy_three", 3);
      flush = 1;
      do_commit(5'd9, 3'd3, 32'h0000_0099);
      do_issue(5'd4, 5'd7, 5'd10, 3'd2, 32'h0, 3'd0, 32'h0, 3'd0, 0);
      tick();
      check_busy("busy_after_flush", 0);
      check("flush_no_src_valid", 32'(src_valid), 32'd0);

      // After flush everything reads ready with committed data.
      do_issue(5'd4, 5'd7, 5'd0, 3'd0, 32'h0000_1234, 3'd0, 32'h0000_0077, 3'd0, 1);
      tick();
      do_issue(5'd9, 5'd3, 5'd0, 3'd0, 32'h0000_0099, 3'd0, 32'hDEAD_BEEF, 3'd0, 1);
      tick();
      check("src_valid_pulse", 32'(src_valid), 32'd1);
      tick();
      check("src_valid_drops", 32'(src_valid), 32'd0);
      check("src_val_held", src_val[31:0], 32'h0000_0099);

      repeat (3) tick();
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
